shiftreg_univ: RTL

- Parametrised universal shift register; successor to the single-bit dffpq/dffprq/dffprsq cells.
- Provides parallel load, left/right shift, rotate, clear, and a self-timed burst engine that performs N shifts/rotates autonomously.
- Intended use: serial links, scan-style test access and serialiser/deserialiser cores built from the cell library.

---
 rtl/shiftreg_univ_if.sv | 28 ++
 rtl/shiftreg_univ.sv | 118 +++++++++++
 2 files changed

// File: rtl/shiftreg_univ_if.sv
// Operation, data and status signals of the universal shift register.
// The master drives operations; the slave is the register itself.
interface shiftreg_univ_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             SET;
  logic             EN;
  logic [2:0]       MODE;
  logic [WIDTH-1:0] D;
  logic             SI;
  logic             START;
  logic [CW-1:0]    COUNT;
  logic [WIDTH-1:0] Q;
  logic             SO;
  logic             BUSY;
  logic             DONE;

  modport master (
    output SET, EN, MODE, D, SI, START, COUNT,
    input  Q, SO, BUSY, DONE
  );

  modport slave (
    input  SET, EN, MODE, D, SI, START, COUNT,
    output Q, SO, BUSY, DONE
  );
endinterface

// File: rtl/shiftreg_univ.sv
// Universal shift register: parallel load, shift, rotate, clear and invert,
// plus a burst engine that runs up to WIDTH shifts/rotates on its own.
module shiftreg_univ #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CW          = $clog2(WIDTH + 1)
) (
  input logic            CLK,
  input logic            RESET,
  shiftreg_univ_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic [2:0]       burst_mode;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    count_sat;
  logic [2:0]       eff_mode;
  logic             so;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       mode,
                                                 input logic [WIDTH-1:0] cur,
                                                 input logic             si,
                                                 input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = cur;
    case (mode)
      3'b001:  r = {cur[WIDTH-2:0], si};
      3'b010:  r = {si, cur[WIDTH-1:1]};
      3'b011:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b100:  r = {cur[0], cur[WIDTH-1:1]};
      3'b101:  r = d;
      3'b110:  r = '0;
      3'b111:  r = ~cur;
      default: r = cur;
    endcase
    return r;
  endfunction

  function automatic logic is_shift(input logic [2:0] mode);
    return (mode >= 3'b001) && (mode <= 3'b100);
  endfunction

  always_comb begin
    count_sat = (bus.COUNT > CNT_MAX) ? CNT_MAX : bus.COUNT;
  end

  // SO follows the latched burst mode while bursting so MODE changes cannot glitch it
  always_comb begin
    eff_mode = (state == BURST) ? burst_mode : bus.MODE;
    case (eff_mode)
      3'b001, 3'b011: so = q[WIDTH-1];
      3'b010, 3'b100: so = q[0];
      default:        so = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q         <= RESET_VALUE;
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else if (bus.SET) begin
      q     <= '1;
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        BURST: begin
          q <= apply_op(burst_mode, q, bus.SI, bus.D);
          if (remaining == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            remaining <= remaining - CW'(1);
          end
        end
        default: begin
          if (bus.START && is_shift(bus.MODE)) begin
            if (count_sat == '0) begin
              done <= 1'b1;
            end else begin
              // First shift of the burst lands on the START edge; remaining excludes it
              q          <= apply_op(bus.MODE, q, bus.SI, bus.D);
              burst_mode <= bus.MODE;
              if (count_sat == CW'(1)) begin
                done <= 1'b1;
              end else begin
                state     <= BURST;
                busy      <= 1'b1;
                remaining <= count_sat - CW'(1);
              end
            end
          end else if (bus.EN) begin
            q <= apply_op(bus.MODE, q, bus.SI, bus.D);
          end
        end
      endcase
    end
  end

  assign bus.Q    = q;
  assign bus.SO   = so;
  assign bus.BUSY = busy;
  assign bus.DONE = done;

endmodule
